cubic_tap_sequencer: RTL

- Upstream controller for the 1-D cubic interpolation engine.
- Accepts one interpolation request: line base address, integer column and 8-bit fraction t.
- Computes the monomial vector {t, t^2, t^3} in Q0.8.
- Fetches the four neighbouring pixels P(-1..2) from a 1-cycle-latency line memory, with border clamping.
- Drives the engine's cycle_cnt/X/P inputs, captures the engine result, and returns it over a valid/ready handshake.

---
 rtl/cubic_tap_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/cubic_tap_sequencer.sv
// cubic_tap_sequencer
// Upstream controller for the 1-D cubic interpolation engine. Accepts one
// request (line base, integer column, Q0.8 fraction t), builds {t, t^2, t^3},
// streams the four clamped neighbour pixels P(-1..2) from a 1-cycle-latency
// line memory into the engine, captures the engine result and returns it over
// a valid/ready handshake.
//
// Optional feature, macro FRAC_ZERO_BYPASS_EN: when defined, a request with
// t == 0 skips the engine. It does a single read at the integer column and
// returns that pixel directly, three cycles after accept.
module cubic_tap_sequencer #(
  parameter int ADDR_W = 14,
  parameter int COL_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [COL_W-1:0]  req_col,
  input  logic [7:0]        req_frac,
  input  logic [COL_W-1:0]  cfg_width,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [2:0]        eng_cycle_cnt,
  output logic [23:0]       eng_x,
  output logic [7:0]        eng_p,
  input  logic [7:0]        eng_out,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [7:0]        res_data
);

  // Column arithmetic is signed and two bits wider than a column so that
  // col-1 below zero and col+2 beyond the width are both representable.
  localparam int CW = COL_W + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_POW1,
    S_POW2,
    S_RUN,
    S_CAPTURE,
    S_DONE,
    S_BREAD,
    S_BCAP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] base_q;
  logic [COL_W-1:0]  col_q;
  logic [7:0]        t_q;
  logic [7:0]        t2_q;
  logic [2:0]        cnt_q;
  logic [23:0]       x_q;
  logic [7:0]        res_q;

  logic [7:0]        t2_calc;
  logic [7:0]        t3_calc;

  logic signed [CW-1:0] tap_ofs;
  logic signed [CW-1:0] tap_col;
  logic signed [CW-1:0] width_m1;
  logic signed [CW-1:0] col_clamped;
  logic [ADDR_W-1:0]    tap_addr;

  logic accept;

  assign accept = (state == S_IDLE) && req_valid;

  // Q0.8 products rounded to nearest; both sums stay below 2^16.
  assign t2_calc = 8'((({8'd0, t_q} * {8'd0, t_q}) + 16'd128) >> 8);
  assign t3_calc = 8'((({8'd0, t2_q} * {8'd0, t_q}) + 16'd128) >> 8);

  // Tap offset relative to the integer column: cnt 0..3 maps to -1..+2 in RUN,
  // and the bypass read uses the column itself.
  // NOTE: every signal assigned in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    tap_ofs = '0;
    if (state == S_RUN) tap_ofs = $signed(CW'(cnt_q)) - $signed(CW'(1));
  end

  assign tap_col  = $signed({2'b00, col_q}) + tap_ofs;
  assign width_m1 = $signed({2'b00, cfg_width}) - $signed(CW'(1));

  // Clamp the tap column into [0, width-1] so border taps replicate edge pixels.
  always_comb begin
    if (tap_col[CW-1])            col_clamped = '0;
    else if (tap_col > width_m1)  col_clamped = width_m1;
    else                          col_clamped = tap_col;
  end

  // Address sum wraps naturally modulo 2^ADDR_W.
  assign tap_addr = base_q + ADDR_W'($unsigned(col_clamped));

  // State register; reset from any state aborts the operation.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
`ifdef FRAC_ZERO_BYPASS_EN
          state_nxt = (req_frac == 8'd0) ? S_BREAD : S_POW1;
`else
          state_nxt = S_POW1;
`endif
        end
      end
      S_POW1:    state_nxt = S_POW2;
      S_POW2:    state_nxt = S_RUN;
      S_RUN:     if (cnt_q == 3'd4) state_nxt = S_CAPTURE;
      S_CAPTURE: state_nxt = S_DONE;
      S_DONE:    if (res_ready) state_nxt = S_IDLE;
`ifdef FRAC_ZERO_BYPASS_EN
      S_BREAD:   state_nxt = S_BCAP;
      S_BCAP:    state_nxt = S_DONE;
`endif
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode; req_ready is also held low during the reset cycle.
  always_comb begin
    req_ready     = 1'b0;
    rd_en         = 1'b0;
    rd_addr       = '0;
    eng_cycle_cnt = 3'd0;
    res_valid     = 1'b0;
    case (state)
      S_IDLE: req_ready = !rst;
      S_RUN: begin
        eng_cycle_cnt = cnt_q;
        if (cnt_q != 3'd4) begin
          rd_en   = 1'b1;
          rd_addr = tap_addr;
        end
      end
      S_DONE: res_valid = 1'b1;
`ifdef FRAC_ZERO_BYPASS_EN
      S_BREAD: begin
        rd_en   = 1'b1;
        rd_addr = tap_addr;
      end
`endif
      default: ;
    endcase
  end

  // Request capture on handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q <= '0;
      col_q  <= '0;
      t_q    <= '0;
    end else if (accept) begin
      base_q <= req_base;
      col_q  <= req_col;
      t_q    <= req_frac;
    end
  end

  // Power pipeline: t^2 in POW1, full monomial vector published at end of POW2.
  always_ff @(posedge clk) begin
    if (rst) begin
      t2_q <= '0;
      x_q  <= '0;
    end else begin
      if (state == S_POW1) t2_q <= t2_calc;
      if (state == S_POW2) x_q  <= {t_q, t2_q, t3_calc};
    end
  end

  // Engine phase counter: 0..4 while in RUN, 0 everywhere else.
  always_ff @(posedge clk) begin
    if (rst)                                   cnt_q <= 3'd0;
    else if (state == S_RUN && cnt_q != 3'd4)  cnt_q <= cnt_q + 3'd1;
    else                                       cnt_q <= 3'd0;
  end

  // Result register, held stable while DONE waits for the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q <= '0;
    end else begin
      if (state == S_CAPTURE) res_q <= eng_out;
`ifdef FRAC_ZERO_BYPASS_EN
      if (state == S_BCAP)    res_q <= rd_data;
`endif
    end
  end

  assign eng_x    = x_q;
  assign eng_p    = rd_data;
  assign res_data = res_q;

endmodule
